// File: rtl/obi_arbiter_2to1_pkg.sv
// Shared OBI interconnect definitions: host identifiers and the
// round-robin pick used when no address phase is locked.
package obi_arbiter_2to1_pkg;

  // Host IDs tagged onto every accepted transaction
  localparam logic OBI_HOST_FETCH = 1'b0;
  localparam logic OBI_HOST_DATA  = 1'b1;

  // Width of one outstanding-transaction ID entry
  localparam int unsigned OBI_ID_W = 1;

  // Pick between the two hosts: a lone requester wins, a tie goes to the
  // host that was not granted last. With no requester the result is unused.
  function automatic logic obi_rr_select(input logic req0,
                                         input logic req1,
                                         input logic last);
    if (req0 && !req1) begin
      return OBI_HOST_FETCH;
    end
    if (req1 && !req0) begin
      return OBI_HOST_DATA;
    end
    return ~last;
  endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// Small in-order FIFO remembering which host issued each accepted
// transaction so responses can be routed back in issue order.
module obi_id_fifo
  import obi_arbiter_2to1_pkg::*;
#(
  parameter int unsigned WIDTH = OBI_ID_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  // A push into a full FIFO or a pop from an empty one is ignored
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer wrap and occupancy bookkeeping
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/obi_arbiter_2to1.sv
// Two-host to one-device OBI arbiter: round-robin selection with an
// address-phase lock, and in-order routing of responses to the issuer.
module obi_arbiter_2to1
  import obi_arbiter_2to1_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // Host 0 (instruction fetch)
  input  logic                h0_req_i,
  output logic                h0_gnt_o,
  input  logic [ADDR_W-1:0]   h0_addr_i,
  input  logic                h0_we_i,
  input  logic [DATA_W/8-1:0] h0_be_i,
  input  logic [DATA_W-1:0]   h0_wdata_i,
  output logic                h0_rvalid_o,
  output logic [DATA_W-1:0]   h0_rdata_o,
  // Host 1 (memory-stage data)
  input  logic                h1_req_i,
  output logic                h1_gnt_o,
  input  logic [ADDR_W-1:0]   h1_addr_i,
  input  logic                h1_we_i,
  input  logic [DATA_W/8-1:0] h1_be_i,
  input  logic [DATA_W-1:0]   h1_wdata_i,
  output logic                h1_rvalid_o,
  output logic [DATA_W-1:0]   h1_rdata_o,
  // Device
  output logic                dev_req_o,
  input  logic                dev_gnt_i,
  output logic [ADDR_W-1:0]   dev_addr_o,
  output logic                dev_we_o,
  output logic [DATA_W/8-1:0] dev_be_o,
  output logic [DATA_W-1:0]   dev_wdata_o,
  input  logic                dev_rvalid_i,
  input  logic [DATA_W-1:0]   dev_rdata_i,
  // Sticky: response seen with nothing outstanding
  output logic                proto_err_o
);

  logic last_q, last_d;
  logic lock_q, lock_d;
  logic lock_owner_q, lock_owner_d;
  logic proto_err_q, proto_err_d;

  logic sel;
  logic req_sel;
  logic handshake;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic fifo_pop;

  // Host selection: a locked address phase keeps its owner, else round-robin
  always_comb begin
    sel = OBI_HOST_FETCH;
    if (lock_q) begin
      sel = lock_owner_q;
    end else begin
      sel = obi_rr_select(h0_req_i, h1_req_i, last_q);
    end
  end

  // Reset gating keeps the device request quiet while rst_ni is low even if
  // a host is already asserting its request.
  assign req_sel   = (sel == OBI_HOST_DATA) ? h1_req_i : h0_req_i;
  assign dev_req_o = req_sel && !fifo_full && rst_ni;
  assign handshake = dev_req_o && dev_gnt_i;

  // Address-phase mux toward the device, zeroed when nothing is requested
  always_comb begin
    dev_addr_o  = '0;
    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_wdata_o = '0;
    if (dev_req_o) begin
      if (sel == OBI_HOST_DATA) begin
        dev_addr_o  = h1_addr_i;
        dev_we_o    = h1_we_i;
        dev_be_o    = h1_be_i;
        dev_wdata_o = h1_wdata_i;
      end else begin
        dev_addr_o  = h0_addr_i;
        dev_we_o    = h0_we_i;
        dev_be_o    = h0_be_i;
        dev_wdata_o = h0_wdata_i;
      end
    end
  end

  assign h0_gnt_o = handshake && (sel == OBI_HOST_FETCH);
  assign h1_gnt_o = handshake && (sel == OBI_HOST_DATA);

  // Responses go to whichever host sits at the FIFO head; the FIFO is
  // cleared while in reset, so no rvalid can leak out then.
  assign fifo_pop    = dev_rvalid_i && !fifo_empty;
  assign h0_rvalid_o = fifo_pop && (fifo_head == OBI_HOST_FETCH);
  assign h1_rvalid_o = fifo_pop && (fifo_head == OBI_HOST_DATA);
  assign h0_rdata_o  = dev_rdata_i;
  assign h1_rdata_o  = dev_rdata_i;
  assign proto_err_o = proto_err_q;

  // Next-state for round-robin history, lock and error flag. The lock holds
  // only while a request is pending without grant, so a host that withdraws
  // its request releases it on the following cycle.
  always_comb begin
    last_d       = last_q;
    lock_d       = dev_req_o && !dev_gnt_i;
    lock_owner_d = lock_owner_q;
    proto_err_d  = proto_err_q;
    if (handshake) begin
      last_d = sel;
    end
    if (lock_d) begin
      lock_owner_d = sel;
    end
    if (dev_rvalid_i && fifo_empty) begin
      proto_err_d = 1'b1;
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q       <= OBI_HOST_DATA;
      lock_q       <= 1'b0;
      lock_owner_q <= OBI_HOST_FETCH;
      proto_err_q  <= 1'b0;
    end else begin
      last_q       <= last_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      proto_err_q  <= proto_err_d;
    end
  end

  obi_id_fifo #(
    .WIDTH (OBI_ID_W),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (sel),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_obi_arbiter_2to1.sv
// Bench for obi_arbiter_2to1: directed scenarios with literal expectations
// followed by random traffic, all checked each cycle against a queue model.
module tb_obi_arbiter_2to1;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  logic          clk;
  logic          rst_n;
  logic          h0_req, h0_gnt, h0_we, h0_rvalid;
  logic [AW-1:0] h0_addr;
  logic [BW-1:0] h0_be;
  logic [DW-1:0] h0_wdata, h0_rdata;
  logic          h1_req, h1_gnt, h1_we, h1_rvalid;
  logic [AW-1:0] h1_addr;
  logic [BW-1:0] h1_be;
  logic [DW-1:0] h1_wdata, h1_rdata;
  logic          dev_req, dev_gnt, dev_we, dev_rvalid, proto_err;
  logic [AW-1:0] dev_addr;
  logic [BW-1:0] dev_be;
  logic [DW-1:0] dev_wdata, dev_rdata;

  // Stimulus staged here and applied to the DUT on the next falling edge
  logic          sRst;
  logic          sReq   [2];
  logic [AW-1:0] sAddr  [2];
  logic          sWe    [2];
  logic [BW-1:0] sBe    [2];
  logic [DW-1:0] sWdata [2];
  logic          sGnt, sRvalid;
  logic [DW-1:0] sRdata;

  // Reference model: last granted host, pending-unanswered-request owner,
  // issue-order queue of host IDs, sticky error
  bit  mLast, mLock, mOwner, mErr;
  int  mQ[$];

  int nTests = 0;
  int nFails = 0;
  int cycle  = 0;

  obi_arbiter_2to1 #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .h0_req_i(h0_req), .h0_gnt_o(h0_gnt), .h0_addr_i(h0_addr), .h0_we_i(h0_we),
    .h0_be_i(h0_be), .h0_wdata_i(h0_wdata), .h0_rvalid_o(h0_rvalid), .h0_rdata_o(h0_rdata),
    .h1_req_i(h1_req), .h1_gnt_o(h1_gnt), .h1_addr_i(h1_addr), .h1_we_i(h1_we),
    .h1_be_i(h1_be), .h1_wdata_i(h1_wdata), .h1_rvalid_o(h1_rvalid), .h1_rdata_o(h1_rdata),
    .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
    .dev_be_o(dev_be), .dev_wdata_o(dev_wdata), .dev_rvalid_i(dev_rvalid),
    .dev_rdata_i(dev_rdata), .proto_err_o(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    rst_n      = sRst;
    h0_req     = sReq[0];   h1_req   = sReq[1];
    h0_addr    = sAddr[0];  h1_addr  = sAddr[1];
    h0_we      = sWe[0];    h1_we    = sWe[1];
    h0_be      = sBe[0];    h1_be    = sBe[1];
    h0_wdata   = sWdata[0]; h1_wdata = sWdata[1];
    dev_gnt    = sGnt;
    dev_rvalid = sRvalid;
    dev_rdata  = sRdata;
  endtask

  // Compute required outputs from the model, compare, then advance the model
  // to the state that follows the upcoming rising edge.
  task automatic checkOutput();
    logic          sel, reqSel, eReq, eWe, eG0, eG1, eRv0, eRv1, eErr;
    logic [AW-1:0] eAddr;
    logic [BW-1:0] eBe;
    logic [DW-1:0] eWdata;
    cycle++;
    sel = 1'b0; reqSel = 1'b0; eReq = 1'b0; eWe = 1'b0; eG0 = 1'b0; eG1 = 1'b0;
    eRv0 = 1'b0; eRv1 = 1'b0; eErr = 1'b0; eAddr = '0; eBe = '0; eWdata = '0;
    if (!rst_n) begin
      mLast = 1'b1; mLock = 1'b0; mOwner = 1'b0; mErr = 1'b0;
      mQ.delete();
    end else begin
      if (mLock)                sel = mOwner;
      else if (h0_req != h1_req) sel = h1_req;
      else                      sel = !mLast;
      reqSel = sel ? h1_req : h0_req;
      eReq   = reqSel && (mQ.size() < MO);
      if (eReq) begin
        eAddr  = sel ? h1_addr  : h0_addr;
        eWe    = sel ? h1_we    : h0_we;
        eBe    = sel ? h1_be    : h0_be;
        eWdata = sel ? h1_wdata : h0_wdata;
      end
      eG0 = eReq && dev_gnt && !sel;
      eG1 = eReq && dev_gnt && sel;
      if (dev_rvalid && mQ.size() > 0) begin
        eRv0 = (mQ[0] == 0);
        eRv1 = (mQ[0] == 1);
      end
      eErr = mErr;
    end
    cmp("dev_req",   64'(dev_req),   64'(eReq));
    cmp("dev_addr",  dev_addr,       eAddr);
    cmp("dev_we",    64'(dev_we),    64'(eWe));
    cmp("dev_be",    64'(dev_be),    64'(eBe));
    cmp("dev_wdata", dev_wdata,      eWdata);
    cmp("h0_gnt",    64'(h0_gnt),    64'(eG0));
    cmp("h1_gnt",    64'(h1_gnt),    64'(eG1));
    cmp("h0_rvalid", 64'(h0_rvalid), 64'(eRv0));
    cmp("h1_rvalid", 64'(h1_rvalid), 64'(eRv1));
    cmp("h0_rdata",  h0_rdata,       dev_rdata);
    cmp("h1_rdata",  h1_rdata,       dev_rdata);
    cmp("proto_err", 64'(proto_err), 64'(eErr));
    if (rst_n) begin
      if (dev_rvalid) begin
        if (mQ.size() > 0) void'(mQ.pop_front());
        else               mErr = 1'b1;
      end
      if (eReq && dev_gnt) begin
        mQ.push_back(int'(sel));
        mLast = sel;
      end
      mLock = eReq && !dev_gnt;
      if (mLock) mOwner = sel;
    end
  endtask

  task automatic runCycle();
    applyStimulus();
    #3;
    checkOutput();
  endtask

  task automatic idle();
    sReq[0] = 1'b0; sReq[1] = 1'b0; sGnt = 1'b0; sRvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    sRst = 1'b0; sRdata = '0;
    for (int h = 0; h < 2; h++) begin
      sReq[h] = 1'b0; sAddr[h] = '0; sWe[h] = 1'b0; sBe[h] = '0; sWdata[h] = '0;
    end
    sGnt = 1'b0; sRvalid = 1'b0;

    // Reset holds everything quiet even with a host requesting
    sReq[0] = 1'b1; sAddr[0] = 64'h100; sGnt = 1'b1;
    runCycle();
    runCycle();
    cmp("rst_dev_req", 64'(dev_req), 64'd0);
    cmp("rst_h0_gnt",  64'(h0_gnt),  64'd0);
    cmp("rst_addr",    dev_addr,     64'd0);
    idle(); sRst = 1'b1;
    runCycle();

    // Tie: grants alternate starting with host 0, responses follow in order
    sAddr[0] = 64'h100; sAddr[1] = 64'h200; sBe[0] = 8'hFF; sBe[1] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      sReq[0] = (i < 4); sReq[1] = (i < 4); sGnt = (i < 4);
      sRvalid = (i > 0); sRdata = 64'hA000 + 64'(i);
      runCycle();
      if (i < 4) begin
        cmp("tie_h0_gnt", 64'(h0_gnt), 64'(i % 2 == 0));
        cmp("tie_h1_gnt", 64'(h1_gnt), 64'(i % 2 == 1));
        cmp("tie_addr", dev_addr, (i % 2 == 0) ? 64'h100 : 64'h200);
      end
      if (i > 0) begin
        cmp("tie_h0_rvalid", 64'(h0_rvalid), 64'((i - 1) % 2 == 0));
        cmp("tie_h1_rvalid", 64'(h1_rvalid), 64'((i - 1) % 2 == 1));
      end
    end
    idle();

    // Lock: host 1 stalled at 0x80 keeps the port although host 0 joins
    sAddr[1] = 64'h80; sAddr[0] = 64'h100;
    for (int i = 0; i < 5; i++) begin
      sReq[1] = (i <= 3); sReq[0] = (i >= 1); sGnt = (i >= 3);
      runCycle();
      if (i <= 3) cmp("lock_addr", dev_addr, 64'h80);
      if (i <= 3) cmp("lock_h0_gnt", 64'(h0_gnt), 64'd0);
      if (i == 3) cmp("lock_h1_gnt", 64'(h1_gnt), 64'd1);
      if (i == 4) cmp("lock_h0_after", 64'(h0_gnt), 64'd1);
    end
    idle(); sRvalid = 1'b1;
    runCycle();
    cmp("lock_rv_h1", 64'(h1_rvalid), 64'd1);
    runCycle();
    cmp("lock_rv_h0", 64'(h0_rvalid), 64'd1);

    // Full: third request stalls until a response frees a slot
    idle(); sAddr[0] = 64'h300;
    for (int i = 0; i < 5; i++) begin
      sReq[0] = 1'b1; sGnt = 1'b1; sRvalid = (i == 3);
      runCycle();
      cmp("full_dev_req", 64'(dev_req), 64'(i < 2 || i == 4));
      if (i == 3) cmp("full_rv_h0", 64'(h0_rvalid), 64'd1);
    end
    idle(); sRvalid = 1'b1;
    runCycle();
    runCycle();

    // Ordering: host 0 read then host 1 byte-masked write
    idle();
    sReq[0] = 1'b1; sWe[0] = 1'b0; sBe[0] = 8'hFF; sAddr[0] = 64'h400; sGnt = 1'b1;
    runCycle();
    cmp("ord_be0",  64'(dev_be), 64'hFF);
    cmp("ord_gnt0", 64'(h0_gnt), 64'd1);
    sReq[0] = 1'b0; sReq[1] = 1'b1; sWe[1] = 1'b1; sBe[1] = 8'h0F;
    sAddr[1] = 64'h500; sWdata[1] = 64'h1234;
    runCycle();
    cmp("ord_be1",    64'(dev_be), 64'h0F);
    cmp("ord_we1",    64'(dev_we), 64'd1);
    cmp("ord_wdata1", dev_wdata,   64'h1234);
    idle(); sWe[1] = 1'b0; sRvalid = 1'b1; sRdata = 64'hDEAD;
    runCycle();
    cmp("ord_rv0",    64'(h0_rvalid), 64'd1);
    cmp("ord_rv0_h1", 64'(h1_rvalid), 64'd0);
    cmp("ord_rdata0", h0_rdata,       64'hDEAD);
    sRdata = 64'hBEEF;
    runCycle();
    cmp("ord_rv1",    64'(h1_rvalid), 64'd1);
    cmp("ord_rv1_h0", 64'(h0_rvalid), 64'd0);

    // Error: response with nothing outstanding
    idle(); sRvalid = 1'b1;
    runCycle();
    cmp("err_rv0",   64'(h0_rvalid), 64'd0);
    cmp("err_rv1",   64'(h1_rvalid), 64'd0);
    cmp("err_early", 64'(proto_err), 64'd0);
    sRvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      runCycle();
      cmp("err_sticky", 64'(proto_err), 64'd1);
    end

    // Async reset with two outstanding, asserted between clock edges
    idle(); sReq[0] = 1'b1; sGnt = 1'b1; sAddr[0] = 64'h600;
    runCycle();
    runCycle();
    sReq[1] = 1'b1; sGnt = 1'b0; sRvalid = 1'b1;
    runCycle();
    cmp("pre_rst_rv0", 64'(h0_rvalid), 64'd1);
    rst_n = 1'b0; sRst = 1'b0;
    #1;
    cmp("arst_dev_req", 64'(dev_req),   64'd0);
    cmp("arst_addr",    dev_addr,       64'd0);
    cmp("arst_rv0",     64'(h0_rvalid), 64'd0);
    cmp("arst_rv1",     64'(h1_rvalid), 64'd0);
    cmp("arst_err",     64'(proto_err), 64'd0);
    sGnt = 1'b1; sRvalid = 1'b0;
    runCycle();
    sRst = 1'b1;
    runCycle();
    cmp("arst_tie_h0", 64'(h0_gnt), 64'd1);
    cmp("arst_tie_h1", 64'(h1_gnt), 64'd0);
    runCycle();
    cmp("arst_tie2_h1", 64'(h1_gnt), 64'd1);

    // Random traffic with occasional spurious responses and resets
    for (int i = 0; i < 600; i++) begin
      sRst = !(i % 150 == 149);
      for (int h = 0; h < 2; h++) begin
        sReq[h]   = ($urandom_range(0, 99) < 60);
        sAddr[h]  = {$urandom, $urandom};
        sWe[h]    = 1'($urandom_range(0, 1));
        sBe[h]    = 8'($urandom);
        sWdata[h] = {$urandom, $urandom};
      end
      sGnt    = ($urandom_range(0, 99) < 55);
      sRvalid = (mQ.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 3);
      sRdata  = {$urandom, $urandom};
      runCycle();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule

// File: doc/obi_arbiter_2to1.md
# obi_arbiter_2to1

Two-host-to-one-device OBI arbiter sharing a single memory port between the instruction fetch driver (host 0) and the memory stage data driver (host 1). Arbitration is round-robin with an address-phase lock. An in-order outstanding-transaction FIFO routes each `rvalid`/`rdata` back to the issuing host. It sits between the two `obi_host_driver` instances and a unified memory or bus interconnect.

## Interface
Parameters:
- `ADDR_W`, 64, address width.
- `DATA_W`, 64, data width; byte-enable width is `DATA_W/8`.
- `MAX_OUTST`, 2, maximum accepted-but-unanswered transactions; power of two, ≥1.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk_i`, in, 1, clock.
  - `rst_ni`, in, 1, asynchronous active-low reset.
- Host ports, x = 0 (fetch) or 1 (data):
  - `hx_req_i` in 1, `hx_gnt_o` out 1, `hx_addr_i` in ADDR_W, `hx_we_i` in 1, `hx_be_i` in DATA_W/8, `hx_wdata_i` in DATA_W.
  - `hx_rvalid_o` out 1, `hx_rdata_o` out DATA_W.
- Device port:
  - Request side: `dev_req_o` out 1, `dev_gnt_i` in 1, `dev_addr_o` out ADDR_W, `dev_we_o` out 1, `dev_be_o` out DATA_W/8, `dev_wdata_o` out DATA_W.
  - Response side: `dev_rvalid_i` in 1, `dev_rdata_i` in DATA_W.
- `proto_err_o`, out, 1, sticky flag: `dev_rvalid_i` arrived with no outstanding transaction.

## Operation
- State:
  - `last_q`: last-granted host, reset 1, so host 0 wins the first tie.
  - `lock_q`: reset 0. `lock_owner_q`: reset 0.
  - Outstanding FIFO: 1-bit host ID entries, `MAX_OUTST` deep; count reset 0, pointers reset 0.
- Selection:
  - If `lock_q`, `sel = lock_owner_q`.
  - Otherwise, if exactly one host requests, select it.
  - If both request, select `~last_q`.
- Request forwarding:
  - `dev_req_o = req_sel && !fifo_full`.
  - Address, `we`, `be` and `wdata` are muxed from `sel`; when `dev_req_o` = 0 they are 0.
- Grant routing:
  - `hx_gnt_o = dev_gnt_i && dev_req_o && (sel == x)`.
  - The non-selected host always sees `gnt` = 0.
- Lock:
  - Set when `dev_req_o` && !`dev_gnt_i`; `lock_owner_q` <= `sel`.
  - Cleared on the handshake `dev_req_o && dev_gnt_i`.
  - While locked, no switching occurs, which preserves OBI address-phase stability.
- Handshake (`dev_req_o && dev_gnt_i`): push `sel` into the FIFO, `last_q <= sel`.
- Response:
  - On `dev_rvalid_i` with FIFO non-empty: pop the head; `h[head]_rvalid_o` = 1.
  - `rdata` goes to both hosts unconditionally; consumers qualify it with `rvalid`.
- Full FIFO:
  - `dev_req_o` is suppressed while full; host requests stay pending with `gnt` = 0.
  - A pop and a grant in the same cycle are allowed only if the FIFO was not full at cycle start. No same-cycle bypass.
- Empty FIFO with `dev_rvalid_i` = 1:
  - No host `rvalid`; FIFO unchanged.
  - `proto_err_o` <= 1 and holds until reset.
- Host drops `req` while locked (protocol violation by the host): clear `lock_q` next cycle; no push.

## Timing
- Request path (`req` → `dev_req_o` → `hx_gnt_o`) is purely combinational: zero added latency.
- Response path (`dev_rvalid_i` → `hx_rvalid_o`) is combinational from the registered FIFO head: zero added latency.
- All state updates on `posedge clk_i`.
- Reset asserted mid-transaction:
  - All state clears immediately.
  - Outstanding responses arriving after reset release hit an empty FIFO and set `proto_err_o`; the device must be reset together with the arbiter.
- Outputs during reset:
  - `dev_req_o`, all `gnt`, all `rvalid` and `proto_err_o` are 0.
  - Muxed data buses are 0.
- Simultaneous push and pop in one cycle: count unchanged; the head advances and the pushed ID lands at the tail.

## Structure
- A shared package holds `OBI_HOST_FETCH` = 0 and `OBI_HOST_DATA` = 1 host-ID constants, reused by other interconnect blocks.
- One natural sub-module: `obi_id_fifo`, a parameterised synchronous FIFO (width 1, depth `MAX_OUTST`) with `push`, `pop`, `full`, `empty`, `head`.
- The arbiter, lock and muxes stay in the top module.

## Test plan
- Tie: h0 and h1 both request at cycle 0, `dev_gnt_i` = 1 constantly.
  - Grants alternate h0, h1, h0, h1.
  - `rvalid` returns 1 cycle later are routed in the same order.
- Lock: h1 alone requests `addr` = 0x80 with `dev_gnt_i` = 0 for 3 cycles; h0 raises `req` at cycle 1.
  - `dev_addr_o` stays 0x80 throughout.
  - Grant goes to h1 at cycle 3, then h0 at cycle 4.
- Full: `MAX_OUTST` = 2, `dev_rvalid_i` held 0.
  - Two grants accepted; on the third request `dev_req_o` = 0.
  - After one `rvalid`, `dev_req_o` returns 1 the next cycle.
- Ordering: grant h0 `read`, then h1 `write` with `be` = 0x0F.
  - `dev_be_o` = 0x0F only in the h1 cycle.
  - First `rvalid` appears on `h0_rvalid_o`, second on `h1_rvalid_o`; `rdata` 0xDEAD reaches h0.
- Error: `dev_rvalid_i` = 1 with empty FIFO.
  - No host `rvalid`; `proto_err_o` rises the next cycle and stays 1 until `rst_ni` = 0.
- Async reset: assert `rst_ni` = 0 mid-cycle with 2 outstanding.
  - All outputs 0 immediately, with no clock edge required.
  - After release, h0 wins the first tie.
